// File: rtl/result_hex_tx.sv
// Formats a captured 32-bit product as an ASCII hex line ("[-]digits\r\n")
// and streams it byte-by-byte over a valid/ready handshake.
module result_hex_tx #(
    parameter bit SIGNED         = 1'b1,
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit UPPERCASE      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, SIGN, DIGIT, CR, LF} state_t;

    state_t      state;
    logic [31:0] mag;
    logic [2:0]  nib_idx;
    logic [2:0]  start_idx;

    logic        cap_neg;
    logic [31:0] cap_mag;
    logic [2:0]  cap_idx;
    logic        accept;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (UPPERCASE ? 8'h41 : 8'h61) + 8'(n - 4'd10);
    endfunction

    function automatic logic [3:0] nibble(input logic [31:0] v, input logic [2:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

    // Index of the most significant non-zero nibble; 0 when the value is zero.
    function automatic logic [2:0] top_nibble(input logic [31:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] != 4'd0) idx = 3'(i);
        end
        return idx;
    endfunction

    // Sign, magnitude and first digit are resolved at capture so no cycles are spent skipping zeros.
    always_comb begin
        cap_neg = SIGNED && in_data[31];
        cap_mag = cap_neg ? 32'(~in_data + 32'd1) : in_data;
        cap_idx = SUPPRESS_ZEROS ? top_nibble(cap_mag) : 3'd7;
    end

    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            mag       <= 32'd0;
            nib_idx   <= 3'd0;
            start_idx <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mag       <= cap_mag;
                        start_idx <= cap_idx;
                        nib_idx   <= cap_idx;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                        if (cap_neg) begin
                            state   <= SIGN;
                            tx_data <= 8'h2D;
                        end else begin
                            state   <= DIGIT;
                            tx_data <= hex_char(nibble(cap_mag, cap_idx));
                        end
                    end
                end
                SIGN: begin
                    if (accept) begin
                        state   <= DIGIT;
                        nib_idx <= start_idx;
                        tx_data <= hex_char(nibble(mag, start_idx));
                    end
                end
                DIGIT: begin
                    if (accept) begin
                        if (nib_idx == 3'd0) begin
                            state   <= CR;
                            tx_data <= 8'h0D;
                        end else begin
                            nib_idx <= nib_idx - 3'd1;
                            tx_data <= hex_char(nibble(mag, nib_idx - 3'd1));
                        end
                    end
                end
                CR: begin
                    if (accept) begin
                        state   <= LF;
                        tx_data <= 8'h0A;
                    end
                end
                LF: begin
                    if (accept) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
